// File: rtl/iq_window_mag_pkg.sv
// Shared constants and FSM encoding for the windowed I/Q magnitude block.
package iq_window_mag_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int LOG2_N_DEF = 8;

    // beta = 3/8 realised as (x >> 2) + (x >> 3)
    localparam int BETA_SH_A = 2;
    localparam int BETA_SH_B = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ABS  = 2'd1,
        ST_MAG  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/iq_window_mag_mag_est.sv
// Alpha-max-beta-min magnitude estimate: registered abs stage, then registered max/min/shift-add.
module iq_mag_est
    import iq_window_mag_pkg::*;
#(
    parameter int S = 16
) (
    input  logic         clk,
    input  logic         rst_in,
    input  logic         abs_en,
    input  logic         mag_en,
    input  logic [S-1:0] i_in,
    input  logic [S-1:0] q_in,
    output logic [S-1:0] mag
);

    logic [S-1:0] abs_i;
    logic [S-1:0] abs_q;
    logic [S-1:0] mx;
    logic [S-1:0] mn;
    logic [S-1:0] mag_nxt;

    // Most negative input maps to 2^(S-1), which still fits as unsigned.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            abs_i <= '0;
            abs_q <= '0;
        end else if (abs_en) begin
            abs_i <= i_in[S-1] ? (~i_in + 1'b1) : i_in;
            abs_q <= q_in[S-1] ? (~q_in + 1'b1) : q_in;
        end
    end

    always_comb begin
        mx = abs_i;
        mn = abs_q;
        if (abs_q > abs_i) begin
            mx = abs_q;
            mn = abs_i;
        end
        mag_nxt = mx + (mn >> BETA_SH_A) + (mn >> BETA_SH_B);
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            mag <= '0;
        end else if (mag_en) begin
            mag <= mag_nxt;
        end
    end

endmodule

// File: rtl/iq_window_mag.sv
// Integrate-and-dump of the I/Q sample stream over 2^LOG2_N samples, with a
// magnitude estimate per window presented on a valid/ready port.
//
// state | meaning
// IDLE  | no result pending; a dump loads the hold registers
// ABS   | absolute values of the held sums being registered
// MAG   | magnitude estimate being registered
// OUT   | out_valid high, waiting for out_ready
module iq_window_mag
    import iq_window_mag_pkg::*;
#(
    parameter  int WIDTH  = WIDTH_DEF,
    parameter  int LOG2_N = LOG2_N_DEF,
    localparam int S      = WIDTH + LOG2_N
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] i_value,
    input  logic [WIDTH-1:0] q_value,
    input  logic             in_valid,
    output logic [S-1:0]     i_sum,
    output logic [S-1:0]     q_sum,
    output logic [S-1:0]     mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    state_t state;
    state_t state_nxt;

    logic [S-1:0]      acc_i;
    logic [S-1:0]      acc_q;
    logic [LOG2_N-1:0] cnt;
    logic [S-1:0]      samp_i;
    logic [S-1:0]      samp_q;
    logic [S-1:0]      tot_i;
    logic [S-1:0]      tot_q;
    logic              dump;

    assign samp_i = {{LOG2_N{i_value[WIDTH-1]}}, i_value};
    assign samp_q = {{LOG2_N{q_value[WIDTH-1]}}, q_value};
    assign tot_i  = acc_i + samp_i;
    assign tot_q  = acc_q + samp_q;
    assign dump   = in_valid && (cnt == '1);

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            acc_i <= '0;
            acc_q <= '0;
            cnt   <= '0;
        end else if (in_valid) begin
            cnt <= cnt + 1'b1;
            if (dump) begin
                acc_i <= '0;
                acc_q <= '0;
            end else begin
                acc_i <= tot_i;
                acc_q <= tot_q;
            end
        end
    end

    // A dump while a result is still in flight (including the handshake cycle) is dropped.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            i_sum   <= '0;
            q_sum   <= '0;
            overrun <= 1'b0;
        end else if (dump) begin
            if (state == ST_IDLE) begin
                i_sum <= tot_i;
                q_sum <= tot_q;
            end else begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (dump) state_nxt = ST_ABS;
            ST_ABS:  state_nxt = ST_MAG;
            ST_MAG:  state_nxt = ST_OUT;
            ST_OUT:  if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign out_valid = (state == ST_OUT);

    iq_mag_est #(
        .S(S)
    ) u_mag_est (
        .clk    (clk),
        .rst_in (rst_in),
        .abs_en (state == ST_ABS),
        .mag_en (state == ST_MAG),
        .i_in   (i_sum),
        .q_in   (q_sum),
        .mag    (mag)
    );

endmodule

// File: tb/tb_iq_window_mag.sv
// Directed bench for iq_window_mag with WIDTH=8, LOG2_N=4 (16-sample windows, 12-bit sums).
module tb_iq_window_mag;

    localparam int WIDTH  = 8;
    localparam int LOG2_N = 4;
    localparam int S      = WIDTH + LOG2_N;

    logic             clk;
    logic             rst_in;
    logic [WIDTH-1:0] i_value;
    logic [WIDTH-1:0] q_value;
    logic             in_valid;
    logic [S-1:0]     i_sum;
    logic [S-1:0]     q_sum;
    logic [S-1:0]     mag;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int i;
        int q;
        int gap;
        int exp_i;
        int exp_q;
        int exp_mag;
    } vec_t;

    vec_t vecs[6];

    iq_window_mag #(
        .WIDTH (WIDTH),
        .LOG2_N(LOG2_N)
    ) dut (
        .clk      (clk),
        .rst_in   (rst_in),
        .i_value  (i_value),
        .q_value  (q_value),
        .in_valid (in_valid),
        .i_sum    (i_sum),
        .q_sum    (q_sum),
        .mag      (mag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int s_of(input logic [S-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int u_of(input logic [S-1:0] v);
        return int'({20'd0, v});
    endfunction

    task automatic drive(input int iv, input int qv);
        logic [31:0] ti;
        logic [31:0] tq;
        ti = iv;
        tq = qv;
        @(negedge clk);
        i_value  = ti[WIDTH-1:0];
        q_value  = tq[WIDTH-1:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_in = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_in = 1'b1;
    endtask

    // Called right after the dump edge; counts from the 16th sample's cycle.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        bit glitch;

        rst_in    = 1'b1;
        i_value   = '0;
        q_value   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{i:   10, q:    0, gap: 0, exp_i:   160, exp_q:     0, exp_mag:  160};
        vecs[1] = '{i: -128, q: -128, gap: 0, exp_i: -2048, exp_q: -2048, exp_mag: 2816};
        vecs[2] = '{i: -128, q: -128, gap: 0, exp_i: -2048, exp_q: -2048, exp_mag: 2816};
        vecs[3] = '{i:   20, q:   10, gap: 2, exp_i:   320, exp_q:   160, exp_mag:  380};
        vecs[4] = '{i:   -1, q:  127, gap: 1, exp_i:   -16, exp_q:  2032, exp_mag: 2038};
        vecs[5] = '{i:  127, q: -128, gap: 0, exp_i:  2032, exp_q: -2048, exp_mag: 2810};

        // Reset state
        @(negedge clk);
        rst_in = 1'b0;
        #1;
        chk("rst i_sum", s_of(i_sum), 0);
        chk("rst q_sum", s_of(q_sum), 0);
        chk("rst mag", u_of(mag), 0);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst overrun", int'(overrun), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_in = 1'b1;

        // Table of single windows, consumer always ready
        for (int v = 0; v < 6; v++) begin
            for (int s = 0; s < 16; s++) begin
                drive(vecs[v].i, vecs[v].q);
                if (s != 15) begin
                    repeat (vecs[v].gap) @(posedge clk);
                end
            end
            wait_valid(lat);
            chk($sformatf("vec%0d latency", v), lat, 3);
            chk($sformatf("vec%0d i_sum", v), s_of(i_sum), vecs[v].exp_i);
            chk($sformatf("vec%0d q_sum", v), s_of(q_sum), vecs[v].exp_q);
            chk($sformatf("vec%0d mag", v), u_of(mag), vecs[v].exp_mag);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d consumed", v), int'(out_valid), 0);
        end
        chk("table overrun", int'(overrun), 0);

        // Back-pressure: 2nd window dropped, 3rd reported
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            if (k == 40) out_ready = 1'b1;
            if (k <= 16)      drive(3, 4);
            else if (k <= 32) drive(5, 5);
            else              drive(-7, 2);
            if (k == 20) begin
                chk("bp w1 valid", int'(out_valid), 1);
                chk("bp w1 i_sum", s_of(i_sum), 48);
                chk("bp w1 mag", u_of(mag), 82);
                chk("bp w1 overrun", int'(overrun), 0);
            end
            if (k == 33) begin
                chk("bp held valid", int'(out_valid), 1);
                chk("bp held i_sum", s_of(i_sum), 48);
                chk("bp held q_sum", s_of(q_sum), 64);
                chk("bp held mag", u_of(mag), 82);
                chk("bp overrun set", int'(overrun), 1);
            end
        end
        wait_valid(lat);
        chk("bp w3 latency", lat, 3);
        chk("bp w3 i_sum", s_of(i_sum), -112);
        chk("bp w3 q_sum", s_of(q_sum), 32);
        chk("bp w3 mag", u_of(mag), 124);
        chk("bp overrun sticky", int'(overrun), 1);
        @(posedge clk);
        #1;

        // Reset mid-window and mid-result
        out_ready = 1'b0;
        for (int k = 0; k < 25; k++) drive(9, 9);
        @(negedge clk);
        rst_in = 1'b0;
        #1;
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst i_sum", s_of(i_sum), 0);
        @(negedge clk);
        rst_in = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) drive(1, -1);
        wait_valid(lat);
        chk("midrst latency", lat, 3);
        chk("midrst i_sum after", s_of(i_sum), 16);
        chk("midrst q_sum after", s_of(q_sum), -16);
        chk("midrst mag after", u_of(mag), 22);
        chk("midrst overrun", int'(overrun), 0);
        @(posedge clk);
        #1;

        // Dump coinciding with the handshake cycle
        do_reset();
        out_ready = 1'b0;
        glitch = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            if (k == 32) out_ready = 1'b1;
            if (k <= 16)      drive(2, 1);
            else if (k <= 32) drive(6, 6);
            else              drive(1, 3);
            if (k == 20) chk("hs w1 mag", u_of(mag), 38);
            if (k == 32) begin
                out_ready = 1'b0;
                chk("hs accepted", int'(out_valid), 0);
                chk("hs overrun", int'(overrun), 1);
            end
            if (k > 32 && out_valid) glitch = 1'b1;
        end
        chk("hs no glitch", int'(glitch), 0);
        out_ready = 1'b1;
        wait_valid(lat);
        chk("hs w3 latency", lat, 3);
        chk("hs w3 i_sum", s_of(i_sum), 16);
        chk("hs w3 q_sum", s_of(q_sum), 48);
        chk("hs w3 mag", u_of(mag), 54);
        chk("hs overrun sticky", int'(overrun), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
